// File: rtl/pwm_bank_if.sv
// pwm_bank_if - register write bus between the SPI register decoder and
// the PWM bank.
//   wr_en    single-cycle write strobe
//   wr_addr  register address (ADDR_W bits)
//   wr_data  write data (CNT_W bits)
// Modports: master (decoder side, drives the bus), slave (PWM bank side).
interface pwm_bank_if #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/pwm_bank.sv
// pwm_bank - multi-channel PWM generator with a shared prescaler and period
// counter and per-channel double-buffered duty, enable and polarity.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   bus          register write bus (pwm_bank_if.slave)
//   pwm_out      registered PWM outputs, one bit per channel
//   period_tick  one-cycle pulse in the cycle after each period wrap
// Register map: 0..CHANNELS-1 duty shadow, CHANNELS enable mask,
// CHANNELS+1 prescaler, CHANNELS+2 polarity mask; other addresses ignored.
module pwm_bank #(
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 8,
  parameter int PRESC_W  = 8,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  pwm_bank_if.slave           bus,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);

  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [ADDR_W-1:0] ADDR_EN    = ADDR_W'(CHANNELS);
  localparam logic [ADDR_W-1:0] ADDR_PRESC = ADDR_W'(CHANNELS + 1);
  localparam logic [ADDR_W-1:0] ADDR_POL   = ADDR_W'(CHANNELS + 2);

  logic [PRESC_W-1:0]  pc_reg;
  logic [PRESC_W-1:0]  presc_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [CHANNELS-1:0] en_reg;
  logic [CHANNELS-1:0] pol_reg;

  logic tick;
  logic boundary;
  logic presc_wr;
  logic en_wr;
  logic pol_wr;

  assign tick     = (pc_reg == presc_reg);
  assign boundary = tick && (cnt_reg == CNT_MAX);
  assign presc_wr = bus.wr_en && (bus.wr_addr == ADDR_PRESC);
  assign en_wr    = bus.wr_en && (bus.wr_addr == ADDR_EN);
  assign pol_wr   = bus.wr_en && (bus.wr_addr == ADDR_POL);

  // Prescaler: a write to P restarts the count so the new value governs
  // the very next tick interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= '0;
      presc_reg <= '0;
    end else begin
      if (presc_wr) begin
        pc_reg    <= '0;
        presc_reg <= bus.wr_data[PRESC_W-1:0];
      end else if (tick) begin
        pc_reg <= '0;
      end else begin
        pc_reg <= pc_reg + PRESC_W'(1);
      end
    end
  end

  // Shared period counter, enable/polarity masks and the wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      en_reg      <= '0;
      pol_reg     <= '0;
      period_tick <= 1'b0;
    end else begin
      if (tick) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (en_wr) begin
        en_reg <= bus.wr_data[CHANNELS-1:0];
      end
      if (pol_wr) begin
        pol_reg <= bus.wr_data[CHANNELS-1:0];
      end
      period_tick <= boundary;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [CNT_W-1:0] shadow_reg;
      logic [CNT_W-1:0] active_reg;
      logic             out_reg;
      logic             duty_wr;
      logic             cmp;

      assign duty_wr = bus.wr_en && (bus.wr_addr == ADDR_W'(gi));
      // All-ones duty is treated as 100% so a channel can be held high.
      assign cmp     = (active_reg == CNT_MAX) || (cnt_reg < active_reg);

      // The active duty loads the pre-edge shadow, so a write landing on
      // the boundary edge waits for the following boundary.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg <= '0;
          active_reg <= '0;
          out_reg    <= 1'b0;
        end else begin
          if (duty_wr) begin
            shadow_reg <= bus.wr_data;
          end
          if (boundary) begin
            active_reg <= shadow_reg;
          end
          out_reg <= en_reg[gi] ? (cmp ^ pol_reg[gi]) : pol_reg[gi];
        end
      end

      assign pwm_out[gi] = out_reg;
    end
  endgenerate

endmodule
